// File: rtl/display_scan_ctrl_if.sv
// display_scan_ctrl_if
//   Bundles the scan controller's enable input and display-drive outputs.
//   Signals:
//     en     - scan enable (0 freezes scanning and darkens the display)
//     select - nibble mux select, 1 = switch1 nibble (digit 1), 0 = switch2 nibble (digit 2)
//     an1_n  - digit-1 anode enable, active-low
//     an2_n  - digit-2 anode enable, active-low
//     frame  - one-cycle strobe at the end of a full frame
//   Modports: master drives en and observes the display signals;
//             slave is the controller side.
interface display_scan_ctrl_if;
  logic en;
  logic select;
  logic an1_n;
  logic an2_n;
  logic frame;

  modport master (output en, input select, input an1_n, input an2_n, input frame);
  modport slave  (input en, output select, output an1_n, output an2_n, output frame);
endinterface

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexing controller for a dual seven-segment display. Alternates
//   the nibble mux select between digit 1 and digit 2, lighting each digit's
//   anode for DWELL cycles per visit. When built with SCAN_BLANK_EN defined,
//   both anodes are dark for BLANK cycles before each digit is lit, so the
//   select change always happens with the display off.
//   Parameters:
//     DWELL - cycles each digit is lit per visit (>= 1)
//     BLANK - cycles of blanking before each digit (SCAN_BLANK_EN only, >= 1)
//   Ports:
//     clk   - system clock
//     reset - synchronous, active-low reset
//     scan  - display_scan_ctrl_if.slave (en in; select, an1_n, an2_n, frame out)
//   Configuration macro: SCAN_BLANK_EN (undefined = SHOW1 <-> SHOW2 only).
module display_scan_ctrl #(
  parameter int unsigned DWELL = 50000,
  parameter int unsigned BLANK = 500
) (
  input  logic                clk,
  input  logic                reset,
  display_scan_ctrl_if.slave  scan
);

  localparam int unsigned MAXC = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DLAST = CW'(DWELL - 1);

`ifdef SCAN_BLANK_EN
  localparam logic [CW-1:0] BLAST = CW'(BLANK - 1);
  typedef enum logic [1:0] {BLANK_TO1, SHOW1, BLANK_TO2, SHOW2} state_t;
  localparam state_t RESET_ST = BLANK_TO1;
`else
  typedef enum logic {SHOW1, SHOW2} state_t;
  localparam state_t RESET_ST = SHOW1;
`endif

  state_t        state;
  state_t        nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lim;
  logic          sel_q;
  logic          an1_q;
  logic          an2_q;

  // {select, an1_n, an2_n} decoded from a state
  function automatic logic [2:0] decode(input state_t s);
    logic [2:0] d;
    d = 3'b111;
    case (s)
`ifdef SCAN_BLANK_EN
      BLANK_TO1: d = 3'b111;
      BLANK_TO2: d = 3'b011;
`endif
      SHOW1:     d = 3'b101;
      SHOW2:     d = 3'b010;
      default:   d = 3'b111;
    endcase
    return d;
  endfunction

  always_comb begin
    nxt = RESET_ST;
    lim = DLAST;
    case (state)
`ifdef SCAN_BLANK_EN
      BLANK_TO1: begin nxt = SHOW1;     lim = BLAST; end
      SHOW1:     begin nxt = BLANK_TO2; lim = DLAST; end
      BLANK_TO2: begin nxt = SHOW2;     lim = BLAST; end
      SHOW2:     begin nxt = BLANK_TO1; lim = DLAST; end
`else
      SHOW1:     begin nxt = SHOW2;     lim = DLAST; end
      SHOW2:     begin nxt = SHOW1;     lim = DLAST; end
`endif
      default:   begin nxt = RESET_ST;  lim = DLAST; end
    endcase
  end

  // Outputs are registered alongside the state: the decoded value of the
  // state being entered is loaded on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state                 <= RESET_ST;
      cnt                   <= '0;
      {sel_q, an1_q, an2_q} <= decode(RESET_ST);
    end else if (scan.en) begin
      if (cnt == lim) begin
        state                 <= nxt;
        cnt                   <= '0;
        {sel_q, an1_q, an2_q} <= decode(nxt);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Anode gating by en and reset is combinational so darkening is immediate.
  assign scan.select = sel_q;
  assign scan.an1_n  = an1_q | ~scan.en | ~reset;
  assign scan.an2_n  = an2_q | ~scan.en | ~reset;
  assign scan.frame  = reset & scan.en & (state == SHOW2) & (cnt == DLAST);

endmodule

// File: tb/tb_display_scan_ctrl.sv
// tb_display_scan_ctrl
//   Directed and randomized stimulus for display_scan_ctrl (DWELL=4, BLANK=2)
//   checked against a position-in-frame reference model.
module tb_display_scan_ctrl;

  localparam int unsigned D = 4;
  localparam int unsigned B = 2;
`ifdef SCAN_BLANK_EN
  localparam int unsigned FL = 2 * (D + B);
`else
  localparam int unsigned FL = 2 * D;
`endif

  logic clk = 1'b0;
  logic reset;
  display_scan_ctrl_if scan ();

  display_scan_ctrl #(.DWELL(D), .BLANK(B)) dut (
    .clk   (clk),
    .reset (reset),
    .scan  (scan.slave)
  );

  always #5 clk = ~clk;

  int   n_total = 0;
  int   n_pass  = 0;
  int   cyc     = 0;
  int   p       = 0;   // cycles elapsed in the current frame
  logic valid   = 1'b0; // model known after the first reset edge

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cycle=%0d observed=%0b expected=%0b", tag, cyc, obs, exp);
  endtask

  // Expected ungated {select, an1_n, an2_n} from frame position.
  function automatic logic [2:0] phase_out(input int pos);
`ifdef SCAN_BLANK_EN
    if (pos < B)               return 3'b111;
    else if (pos < B + D)      return 3'b101;
    else if (pos < 2 * B + D)  return 3'b011;
    else                       return 3'b010;
`else
    if (pos < D) return 3'b101;
    else         return 3'b010;
`endif
  endfunction

  task automatic step(input logic r, input logic e);
    logic [2:0] x;
    logic gate;
    reset   = r;
    scan.en = e;
    @(negedge clk);
    gate = r & e;
    x = phase_out(p);
    chk("an1_n", scan.an1_n, valid ? (x[1] | ~gate) : 1'b1);
    chk("an2_n", scan.an2_n, valid ? (x[0] | ~gate) : 1'b1);
    if (valid) begin
      chk("select", scan.select, x[2]);
      chk("frame", scan.frame, gate && (p == FL - 1));
      chk("anode_excl", ~(~scan.an1_n & ~scan.an2_n), 1'b1);
      chk("sel_match", (scan.an1_n | scan.select) & (scan.an2_n | ~scan.select), 1'b1);
    end
    @(posedge clk);
    if (!r) begin
      p = 0;
      valid = 1'b1;
    end else if (e) begin
      p = (p + 1) % FL;
    end
    cyc++;
    #1;
  endtask

  initial begin
    reset   = 1'b0;
    scan.en = 1'b1;
    #1;
    // reset held with en high
    repeat (3) step(1'b0, 1'b1);
    // two full frames
    repeat (2 * FL) step(1'b1, 1'b1);
    // stall after the 2nd digit-1 cycle
`ifdef SCAN_BLANK_EN
    repeat (B + 2) step(1'b1, 1'b1);
`else
    repeat (2) step(1'b1, 1'b1);
`endif
    repeat (3) step(1'b1, 1'b0);
    repeat (FL) step(1'b1, 1'b1);
    // reset during the 3rd digit-2 cycle
    for (int i = 0; i < int'(FL) && p != int'(FL - D + 2); i++) step(1'b1, 1'b1);
    chk("reach_show2", (p == int'(FL - D + 2)), 1'b1);
    step(1'b0, 1'b1);
    repeat (FL + 2) step(1'b1, 1'b1);
    // random soak
    for (int i = 0; i < 2000; i++)
      step(($urandom % 200) != 0, ($urandom % 4) != 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
